// File: rtl/hamming_dec_engine.sv
// SECDED decoder for Hamming(16,11) words held as byte pairs in data memory.
// Reads NUM_WORDS words from SRC_BASE and writes {status, message} pairs to DST_BASE.
module hamming_dec_engine #(
    parameter int AW        = 8,
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0,
    parameter int NUM_WORDS = 15
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    output logic          done,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic [3:0]    single_cnt,
    output logic [3:0]    double_cnt
);

    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_HI,
        RD_LO,
        CAPT,
        DEC,
        WR_HI,
        WR_LO,
        FIN
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [15:0]     word_p0;
    logic [7:0]      lo_p1;
    logic [12:0]     dec;
    logic [1:0]      dec_status;
    logic [10:0]     dec_msg;

    // Word i lives at base+2i (low byte) and base+2i+1 (high byte).
    function automatic logic [AW-1:0] byte_addr(input int base, input logic [IW-1:0] i,
                                                input logic hi);
        return AW'(base + 2 * int'(i) + int'(hi));
    endfunction

    function automatic logic [3:0] syndrome(input logic [15:0] w);
        logic [3:0] s;
        s = '0;
        for (int k = 1; k < 16; k++) begin
            if (w[k]) s = s ^ 4'(k);
        end
        return s;
    endfunction

    // Returns {status, d11..d1}; a single error at position s is flipped back first.
    function automatic logic [12:0] decode(input logic [15:0] w);
        logic [3:0]  s;
        logic        p;
        logic [15:0] c;
        logic [1:0]  st;
        s  = syndrome(w);
        p  = ^w;
        c  = w;
        st = 2'b00;
        if (p) begin
            st = 2'b01;
            if (s != 4'd0) c[s] = ~c[s];
        end else if (s != 4'd0) begin
            st = 2'b10;
        end
        return {st, c[15:9], c[7:5], c[3]};
    endfunction

    always_comb begin
        dec        = decode(word_p0);
        dec_status = dec[12:11];
        dec_msg    = dec[10:0];
    end

    // Datapath registers carry no reset; the FSM only reads them after loading.
    always_ff @(posedge clock) begin
        if (state == RD_LO) word_p0[15:8] <= mem_rdata;
        if (state == CAPT)  word_p0[7:0]  <= mem_rdata;
        if (state == DEC)   lo_p1         <= dec_msg[7:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            done       <= 1'b0;
            busy       <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            single_cnt <= '0;
            double_cnt <= '0;
            idx        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RD_HI;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        single_cnt <= '0;
                        double_cnt <= '0;
                        idx        <= '0;
                        mem_addr   <= byte_addr(SRC_BASE, '0, 1'b1);
                    end
                end
                RD_HI: begin
                    state    <= RD_LO;
                    mem_addr <= byte_addr(SRC_BASE, idx, 1'b0);
                end
                RD_LO: state <= CAPT;
                CAPT:  state <= DEC;
                DEC: begin
                    state     <= WR_HI;
                    mem_addr  <= byte_addr(DST_BASE, idx, 1'b1);
                    mem_wr_en <= 1'b1;
                    mem_wdata <= {dec_status, 3'b000, dec_msg[10:8]};
                    case (dec_status)
                        2'b01: if (single_cnt != 4'hF) single_cnt <= single_cnt + 4'd1;
                        2'b10: if (double_cnt != 4'hF) double_cnt <= double_cnt + 4'd1;
                        default: ;
                    endcase
                end
                WR_HI: begin
                    state     <= WR_LO;
                    mem_addr  <= byte_addr(DST_BASE, idx, 1'b0);
                    mem_wdata <= lo_p1;
                end
                WR_LO: begin
                    mem_wr_en <= 1'b0;
                    if (idx == LAST) begin
                        state <= FIN;
                    end else begin
                        idx      <= idx + 1'b1;
                        state    <= RD_HI;
                        mem_addr <= byte_addr(SRC_BASE, IW'(idx + 1'b1), 1'b1);
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Randomised bench for hamming_dec_engine against a behavioural SECDED model,
// with a per-cycle compare process and a few hand-computed literal results.
module tb_hamming_dec_engine;

    localparam int AW  = 8;
    localparam int SRC = 30;
    localparam int DST = 0;
    localparam int NW  = 15;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic          done;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic [3:0]    single_cnt;
    logic [3:0]    double_cnt;

    hamming_dec_engine #(
        .AW(AW), .SRC_BASE(SRC), .DST_BASE(DST), .NUM_WORDS(NW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .done(done), .busy(busy),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .single_cnt(single_cnt), .double_cnt(double_cnt)
    );

    always #5 clock = ~clock;

    logic [7:0]  mem [0:255];
    logic [15:0] src_w [NW];
    int          exp_hi [NW];
    int          exp_lo [NW];
    int          cum_s [NW];
    int          cum_d [NW];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    bit          mon_en = 1'b0;

    always @(posedge clock) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Message bits fill the non-power-of-two positions 3..15 in order; each parity
    // bit makes its group even, and bit 0 makes the whole word even.
    function automatic logic [15:0] encode(input logic [10:0] m);
        logic [15:0] w;
        logic        x;
        int          b;
        w = '0;
        b = 0;
        for (int k = 3; k < 16; k++) begin
            if ((k & (k - 1)) != 0) begin
                w[k] = m[b];
                b++;
            end
        end
        for (int p = 1; p < 16; p = p * 2) begin
            x = 1'b0;
            for (int k = 1; k < 16; k++) if ((k & p) != 0 && k != p) x = x ^ w[k];
            w[p] = x;
        end
        w[0] = ^w[15:1];
        return w;
    endfunction

    // Returns status*2048 + message.
    function automatic int ref_decode(input logic [15:0] w);
        logic [15:0] c;
        int          s;
        int          st;
        int          m;
        int          b;
        s = 0;
        for (int k = 1; k < 16; k++) if (w[k]) s = s ^ k;
        c  = w;
        st = 0;
        if ($countones(w) % 2 == 1) begin
            st = 1;
            if (s != 0) c[s] = ~c[s];
        end else if (s != 0) begin
            st = 2;
        end
        m = 0;
        b = 0;
        for (int k = 3; k < 16; k++) begin
            if ((k & (k - 1)) != 0) begin
                if (c[k]) m = m | (1 << b);
                b++;
            end
        end
        return st * 2048 + m;
    endfunction

    function automatic logic [15:0] rand_word(input int max_flips);
        logic [15:0] w;
        int          n;
        int          b1;
        int          b2;
        w  = encode(11'($urandom_range(2047)));
        n  = $urandom_range(max_flips);
        b1 = $urandom_range(15);
        if (n >= 1) w[b1] = ~w[b1];
        if (n == 2) begin
            b2 = $urandom_range(15);
            while (b2 == b1) b2 = $urandom_range(15);
            w[b2] = ~w[b2];
        end
        return w;
    endfunction

    task automatic prepare();
        int r;
        int s;
        int d;
        s = 0;
        d = 0;
        for (int a = 0; a < 256; a++) mem[a] <= 8'hA5;
        for (int i = 0; i < NW; i++) begin
            mem[SRC + 2 * i]     <= src_w[i][7:0];
            mem[SRC + 2 * i + 1] <= src_w[i][15:8];
            r = ref_decode(src_w[i]);
            exp_hi[i] = (r / 2048) * 64 + (r % 2048) / 256;
            exp_lo[i] = r % 256;
            if (r / 2048 == 1 && s < 15) s++;
            if (r / 2048 == 2 && d < 15) d++;
            cum_s[i] = s;
            cum_d[i] = d;
        end
        @(negedge clock);
    endtask

    int mj;
    int mi;
    int mph;
    int nd;
    bit exp_wr;

    // Edge j after the start-sampling edge: word i occupies edges 6i+1..6i+6,
    // writes land after edges 6i+4 (high) and 6i+5 (low), done after 6*NW+1.
    always @(negedge clock) begin
        if (mon_en) begin
            mj = cyc - start_cyc;
            if (mj >= 1 && mj <= 6 * NW + 1) begin
                mi  = (mj - 1) / 6;
                mph = mj % 6;
                check("busy", busy, 32'(mj <= 6 * NW));
                check("done", done, 32'(mj == 6 * NW + 1));
                exp_wr = (mj <= 6 * NW) && (mph == 4 || mph == 5);
                check("wr_en", mem_wr_en, 32'(exp_wr));
                if (exp_wr) begin
                    check("wr_addr", mem_addr, (mph == 4) ? DST + 2 * mi + 1 : DST + 2 * mi);
                    check("wr_data", mem_wdata, (mph == 4) ? exp_hi[mi] : exp_lo[mi]);
                end
                if (mph == 1 && mj < 6 * NW) check("rd_lo_addr", mem_addr, SRC + 2 * mi);
                if (mph == 0 && mj < 6 * NW) check("rd_hi_addr", mem_addr, SRC + 2 * (mj / 6) + 1);
                nd = (mj >= 4) ? (mj - 4) / 6 + 1 : 0;
                if (nd > NW) nd = NW;
                check("single_live", single_cnt, (nd == 0) ? 0 : cum_s[nd - 1]);
                check("double_live", double_cnt, (nd == 0) ? 0 : cum_d[nd - 1]);
            end
        end
    end

    task automatic run_once(input int glitch_at, input int reset_at);
        int j;
        bit fin;
        bit aborted;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
        mon_en    = 1'b1;
        fin       = 1'b0;
        aborted   = 1'b0;
        for (int t = 0; t < 6 * NW + 10 && !fin && !aborted; t++) begin
            @(negedge clock);
            #1;
            j     = cyc - start_cyc;
            start = (j == glitch_at);
            if (j == reset_at) begin
                mon_en  = 1'b0;
                reset_n = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_wr_en", mem_wr_en, 0);
                check("rst_addr", mem_addr, 0);
                check("rst_single", single_cnt, 0);
                aborted = 1'b1;
            end else if (done) begin
                fin = 1'b1;
                check("done_edge", j, 6 * NW + 1);
            end
        end
        mon_en = 1'b0;
        start  = 1'b0;
        if (aborted) begin
            repeat (2) @(negedge clock);
            reset_n = 1'b1;
            @(negedge clock);
            check("partial_w6_lo", mem[DST + 12], exp_lo[6]);
            check("partial_w6_hi", mem[DST + 13], exp_hi[6]);
            check("partial_w7_hi", mem[DST + 15], 8'hA5);
            check("idle_busy", busy, 0);
            return;
        end
        if (!fin) begin
            check("done_timeout", 0, 1);
            return;
        end
        repeat (3) @(negedge clock);
        check("done_hold", done, 1);
        check("busy_idle", busy, 0);
        check("single_final", single_cnt, cum_s[NW - 1]);
        check("double_final", double_cnt, cum_d[NW - 1]);
        for (int i = 0; i < NW; i++) begin
            check("dst_hi", mem[DST + 2 * i + 1], exp_hi[i]);
            check("dst_lo", mem[DST + 2 * i], exp_lo[i]);
            check("src_hi", mem[SRC + 2 * i + 1], src_w[i][15:8]);
            check("src_lo", mem[SRC + 2 * i], src_w[i][7:0]);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        check("reset_wr_en", mem_wr_en, 0);
        check("reset_addr", mem_addr, 0);
        check("reset_wdata", mem_wdata, 0);
        check("reset_single", single_cnt, 0);
        check("reset_double", double_cnt, 0);

        // All-zero source words decode clean to zero.
        for (int i = 0; i < NW; i++) src_w[i] = 16'h0000;
        prepare();
        run_once(-1, -1);
        for (int i = 0; i < 2 * NW; i++) check("zero_dst", mem[DST + i], 8'h00);
        check("zero_single", single_cnt, 0);
        check("zero_double", double_cnt, 0);

        // Hand-decoded words: clean, single data flip, p0 flip, double flip.
        src_w[0] = 16'hFFFF;
        src_w[1] = 16'hFFDF;
        src_w[2] = 16'hFFFE;
        src_w[3] = 16'hFDDF;
        for (int i = 4; i < NW; i++) src_w[i] = rand_word(0);
        prepare();
        run_once(-1, -1);
        check("lit_ffff_hi", mem[DST + 1], 8'h07);
        check("lit_ffff_lo", mem[DST + 0], 8'hFF);
        check("lit_ffdf_hi", mem[DST + 3], 8'h47);
        check("lit_ffdf_lo", mem[DST + 2], 8'hFF);
        check("lit_fffe_hi", mem[DST + 5], 8'h47);
        check("lit_fffe_lo", mem[DST + 4], 8'hFF);
        check("lit_fddf_hi", mem[DST + 7], 8'h87);
        check("lit_fddf_lo", mem[DST + 6], 8'hED);
        check("lit_single", single_cnt, 2);
        check("lit_double", double_cnt, 1);

        // Random words with 0..2 flips; a second start mid-run must be ignored.
        for (int i = 0; i < NW; i++) src_w[i] = rand_word(2);
        prepare();
        run_once(20, -1);

        // Reset while word 7 is being written back.
        for (int i = 0; i < NW; i++) src_w[i] = rand_word(2);
        prepare();
        run_once(-1, 6 * 7 + 4);

        // Clean rerun after reset.
        for (int i = 0; i < NW; i++) src_w[i] = rand_word(2);
        prepare();
        run_once(-1, -1);

        for (int i = 0; i < NW; i++) src_w[i] = rand_word(2);
        prepare();
        run_once(-1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming_dec_engine.md
Name: hamming_dec_engine

Overview:
- Hardware SECDED decoder for the Hamming(16,11) words that the program-1 encoder leaves in data memory.
- Walks NUM_WORDS encoded 16-bit words, stored as byte pairs starting at SRC_BASE.
- For each word it corrects a single-bit error or detects a double-bit error.
- It writes the 11-bit message plus a 2-bit status back to memory at DST_BASE. Status and counters are reported to the top level.
- Uses the same start/done handshake as top_level.

Parameters:
- AW, 8, data-memory address width
- SRC_BASE, 30, byte address of the first encoded word's low byte
- DST_BASE, 0, byte address of the first decoded word's low byte
- NUM_WORDS, 15, number of words processed per start

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request pulse, sampled in IDLE only
- done  output  1  program complete, level
- busy  output  1  engine walking memory
- mem_addr  output  AW  data-memory byte address
- mem_wr_en  output  1  write strobe for mem_addr/mem_wdata
- mem_wdata  output  8  write data
- mem_rdata  input  8  read data, valid one cycle after mem_addr (synchronous read)
- single_cnt  output  4  words flagged corrected (status 01) this run
- double_cnt  output  4  words flagged uncorrectable (status 10) this run

Behaviour:
- Reset (async, reset_n=0): state=IDLE; done, busy, mem_wr_en, single_cnt, double_cnt = 0; mem_addr and mem_wdata = 0; word index = 0.
- Memory layout: word i is read as {mem[SRC_BASE+2i+1], mem[SRC_BASE+2i]} = w[15:0].
- Encoded bit mapping: w = {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}. Bit position k (1..15) is Hamming position k; w[0] is overall parity.
- Syndrome s[3:0] = XOR of all k in 1..15 with w[k]=1. Overall parity P = ^w.
- Decode rules:
  - s=0, P=0: clean; status 00.
  - s≠0, P=1: flip w[s]; status 01; single_cnt++.
  - s=0, P=1: p0 error, data intact; status 01; single_cnt++.
  - s≠0, P=0: double error; status 10; data taken uncorrected; double_cnt++.
- Output word i: mem[DST_BASE+2i+1] = {status[1:0], 3'b000, d11, d10, d9}; mem[DST_BASE+2i] = d8..d1.
- FSM, one state per cycle:
  - IDLE: start=1 → RD_HI; clear counters and index, clear done, set busy.
  - RD_HI: mem_addr = hi source address.
  - RD_LO: mem_addr = lo source address; capture mem_rdata as w[15:8].
  - CAPT: capture w[7:0].
  - DEC: register corrected data, status, counter update.
  - WR_HI: mem_wr_en=1 at the hi destination address.
  - WR_LO: mem_wr_en=1 at the lo destination address. If index=NUM_WORDS-1 → FIN, else index++ → RD_HI.
  - FIN: busy=0, done=1 → IDLE.
- Latency: 6 cycles per word. done rises 6*NUM_WORDS+1 edges after the edge that samples start.
- done stays high in IDLE until the next accepted start clears it.
- start while busy is ignored; no restart and no re-latch.
- mem_wr_en is high only in WR_HI and WR_LO, for exactly one cycle each. Source bytes are never written.
- Counters saturate at 15.
- Reset mid-run: immediate return to IDLE with all outputs at reset values. Partially written results stay in memory; no completion of the current word.

Test Plan:
- All 15 source words 0x0000, pulse start → every destination pair 0x00/0x00, counts 0/0, done at edge 91, no writes to bytes 30-59.
- Word 0xFFFF (message 0x7FF) → hi 0x07, lo 0xFF, status 00.
- 0xFFDF (bit 5 flipped) → hi 0x47, lo 0xFF, single_cnt=1.
- 0xFFFE (p0 flipped) → hi 0x47, lo 0xFF, single_cnt=1.
- 0xFDDF (bits 5 and 9 flipped) → hi 0x87, lo 0xED, double_cnt=1.
- 15 random encoder outputs with 0/1/2 random flips → golden-model match on all 30 bytes and on both counters.
- Second start pulse during busy → ignored, done timing unchanged.
- reset_n low at word 7 → busy, done and mem_wr_en at 0 at once.
- New start after reset_n rises → full clean rerun with counters starting from 0.
